// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired control-step sequencer for a simple bus-based datapath
//
// Walks each instruction through fetch (T0..T2) and execute (T3..T5) steps and
// raises the bus, register and ALU controls for the current step.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-high reset; forces RESET and zeroes all outputs
//   IR       instruction register; [31:27] opcode, ra/rb/rc fields go to the select logic
//   Stop     run-hold request, sampled only in T0
//   PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read
//            datapath bus and register-load controls
//   ADD, SUB, AND, OR, NEG, NOT
//            ALU operation selects, zero-or-one-hot
//   Gra, Grb, Grc, Rin, Rout
//            register-file select and in/out strobes
//   Run      high whenever the sequencer is neither in RESET nor HALTED
//   Illegal  one-cycle pulse in the step after T3 of an undefined opcode

module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        NEG,
  output logic        NOT,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Run,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_T0     = 3'd1,
    S_T1     = 3'd2,
    S_T2     = 3'd3,
    S_T3     = 3'd4,
    S_T4     = 3'd5,
    S_T5     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  logic [4:0] opcode;
  logic       is_binary;
  logic       is_unary;
  logic       is_halt;
  logic       is_defined;

  // ra/rb/rc are consumed by the downstream select/encode logic, not here.
  logic       unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  assign opcode     = IR[31:27];
  assign is_binary  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
  assign is_unary   = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_halt    = (opcode == OP_HALT);
  assign is_defined = is_binary || is_unary || is_halt || (opcode == OP_NOP);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_RESET;
      Illegal <= 1'b0;
    end else begin
      // Undefined opcodes run as nop; flag them during the step after T3.
      Illegal <= (state == S_T3) && !is_defined;
      case (state)
        S_RESET:  state <= S_T0;
        S_T0:     state <= Stop ? S_T0 : S_T1;
        S_T1:     state <= S_T2;
        S_T2:     state <= S_T3;
        S_T3: begin
          if (is_binary || is_unary) state <= S_T4;
          else if (is_halt)          state <= S_HALTED;
          else                       state <= S_T0;
        end
        S_T4:     state <= is_binary ? S_T5 : S_T0;
        S_T5:     state <= S_T0;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RESET;
      endcase
    end
  end

  assign Run = (state != S_RESET) && (state != S_HALTED);

  // Controls follow the current step only; the opcode is consulted from T3 on,
  // so IR activity during fetch cannot disturb T0..T2.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    ADD     = 1'b0;
    SUB     = 1'b0;
    AND     = 1'b0;
    OR      = 1'b0;
    NEG     = 1'b0;
    NOT     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    case (state)
      S_T0: begin
        // A held Stop parks the sequencer in T0 with every control idle.
        if (!Stop) begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_binary) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (is_unary) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Zin  = 1'b1;
          NEG  = (opcode == OP_NEG);
          NOT  = (opcode == OP_NOT);
        end
      end
      S_T4: begin
        if (is_binary) begin
          Grc  = 1'b1;
          Rout = 1'b1;
          Zin  = 1'b1;
          ADD  = (opcode == OP_ADD);
          SUB  = (opcode == OP_SUB);
          AND  = (opcode == OP_AND);
          OR   = (opcode == OP_OR);
        end else if (is_unary) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
`timescale 1ns/1ps

module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        Stop;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic ADD, SUB, AND, OR, NEG, NOT;
  logic Gra, Grb, Grc, Rin, Rout, Run, Illegal;

  int tests_run = 0;
  int tests_failed = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Run(Run), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] M_PCOUT   = 24'd1 << 23;
  localparam logic [23:0] M_ZLOWOUT = 24'd1 << 22;
  localparam logic [23:0] M_MDROUT  = 24'd1 << 21;
  localparam logic [23:0] M_MARIN   = 24'd1 << 20;
  localparam logic [23:0] M_ZIN     = 24'd1 << 19;
  localparam logic [23:0] M_PCIN    = 24'd1 << 18;
  localparam logic [23:0] M_MDRIN   = 24'd1 << 17;
  localparam logic [23:0] M_IRIN    = 24'd1 << 16;
  localparam logic [23:0] M_YIN     = 24'd1 << 15;
  localparam logic [23:0] M_INCPC   = 24'd1 << 14;
  localparam logic [23:0] M_READ    = 24'd1 << 13;
  localparam logic [23:0] M_ADD     = 24'd1 << 12;
  localparam logic [23:0] M_SUB     = 24'd1 << 11;
  localparam logic [23:0] M_AND     = 24'd1 << 10;
  localparam logic [23:0] M_OR      = 24'd1 << 9;
  localparam logic [23:0] M_NEG     = 24'd1 << 8;
  localparam logic [23:0] M_NOT     = 24'd1 << 7;
  localparam logic [23:0] M_GRA     = 24'd1 << 6;
  localparam logic [23:0] M_GRB     = 24'd1 << 5;
  localparam logic [23:0] M_GRC     = 24'd1 << 4;
  localparam logic [23:0] M_RIN     = 24'd1 << 3;
  localparam logic [23:0] M_ROUT    = 24'd1 << 2;
  localparam logic [23:0] M_RUN     = 24'd1 << 1;
  localparam logic [23:0] M_ILL     = 24'd1 << 0;

  localparam logic [23:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [23:0] E_T1  = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [23:0] E_T2  = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [23:0] E_BIN3 = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [23:0] E_BIN4 = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [23:0] E_WB  = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [23:0] E_UN3 = M_GRB | M_ROUT | M_ZIN | M_RUN;

  logic [23:0] outs;
  assign outs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                 ADD, SUB, AND, OR, NEG, NOT, Gra, Grb, Grc, Rin, Rout, Run, Illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample away from the edge; ALU selects are checked every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    check("alu_onehot0", {31'd0, $onehot0({ADD, SUB, AND, OR, NEG, NOT})}, 32'd1);
  endtask

  task automatic run_instr(input string name, input logic [31:0] ir,
                           input logic [23:0] e3, input logic [23:0] e4,
                           input logic [23:0] e5, input int last, input bit ill);
    IR = ir;
    #0.1;
    check({name, "_T0"}, {8'd0, outs}, {8'd0, E_T0});
    step(); check({name, "_T1"}, {8'd0, outs}, {8'd0, E_T1});
    step(); check({name, "_T2"}, {8'd0, outs}, {8'd0, E_T2});
    step(); check({name, "_T3"}, {8'd0, outs}, {8'd0, e3});
    if (last >= 4) begin step(); check({name, "_T4"}, {8'd0, outs}, {8'd0, e4}); end
    if (last >= 5) begin step(); check({name, "_T5"}, {8'd0, outs}, {8'd0, e5}); end
    step(); check({name, "_next_T0"}, {8'd0, outs}, {8'd0, E_T0 | (ill ? M_ILL : 24'd0)});
  endtask

  initial begin
    clr  = 1'b1;
    IR   = 32'h0;
    Stop = 1'b0;
    #1;
    check("reset_outs", {8'd0, outs}, 32'd0);
    step(); check("reset_hold1", {8'd0, outs}, 32'd0);
    step(); check("reset_hold2", {8'd0, outs}, 32'd0);

    // neg r1 from reset release: T0..T4 then back to T0 on the sixth edge.
    IR  = 32'h88080000;
    clr = 1'b0;
    #0.1;
    check("released_still_reset", {8'd0, outs}, 32'd0);
    step();
    run_instr("neg", 32'h88080000, E_UN3 | M_NEG, E_WB, 24'd0, 4, 1'b0);

    run_instr("add", 32'h1A8A0000, E_BIN3, E_BIN4 | M_ADD, E_WB, 5, 1'b0);
    run_instr("sub", 32'h20000000, E_BIN3, E_BIN4 | M_SUB, E_WB, 5, 1'b0);
    run_instr("and", 32'h50000000, E_BIN3, E_BIN4 | M_AND, E_WB, 5, 1'b0);
    run_instr("or",  32'h58000000, E_BIN3, E_BIN4 | M_OR,  E_WB, 5, 1'b0);
    run_instr("not", 32'h90000000, E_UN3 | M_NOT, E_WB, 24'd0, 4, 1'b0);
    run_instr("nop", 32'hD0000000, M_RUN, 24'd0, 24'd0, 3, 1'b0);

    // Undefined opcode: nop timing, Illegal only in the step after T3, fetch carries on.
    run_instr("undef", 32'hF8000000, M_RUN, 24'd0, 24'd0, 3, 1'b1);
    IR = 32'hD0000000;
    step(); check("undef_fetch_T1", {8'd0, outs}, {8'd0, E_T1});
    step(); check("undef_fetch_T2", {8'd0, outs}, {8'd0, E_T2});
    step(); check("undef_fetch_T3", {8'd0, outs}, {8'd0, M_RUN});
    step(); check("undef_fetch_T0", {8'd0, outs}, {8'd0, E_T0});

    // Stop held in T0: parked with only Run high, then resumes.
    Stop = 1'b1;
    #0.1;
    check("stop_T0_now", {8'd0, outs}, {8'd0, M_RUN});
    for (int i = 0; i < 3; i++) begin
      step(); check("stop_hold", {8'd0, outs}, {8'd0, M_RUN});
    end
    Stop = 1'b0;
    #0.1;
    check("stop_release_T0", {8'd0, outs}, {8'd0, E_T0});
    // Stop is ignored outside T0.
    step(); check("stop_release_T1", {8'd0, outs}, {8'd0, E_T1});
    Stop = 1'b1;
    step(); check("stop_ignored_T2", {8'd0, outs}, {8'd0, E_T2});
    Stop = 1'b0;
    step(); check("stop_ignored_T3", {8'd0, outs}, {8'd0, M_RUN});
    step(); check("stop_after_T0", {8'd0, outs}, {8'd0, E_T0});

    // halt: HALTED for 10 cycles, clr pulse brings it back through RESET to T0.
    IR = 32'hD8000000;
    step(); check("halt_T1", {8'd0, outs}, {8'd0, E_T1});
    step(); check("halt_T2", {8'd0, outs}, {8'd0, E_T2});
    step(); check("halt_T3", {8'd0, outs}, {8'd0, M_RUN});
    for (int i = 0; i < 10; i++) begin
      step(); check("halted", {8'd0, outs}, 32'd0);
    end
    clr = 1'b1;
    #0.1;
    check("halt_clr", {8'd0, outs}, 32'd0);
    step(); check("halt_clr_hold", {8'd0, outs}, 32'd0);
    clr = 1'b0;
    #0.1;
    check("halt_reset_state", {8'd0, outs}, 32'd0);
    step(); check("halt_restart_T0", {8'd0, outs}, {8'd0, E_T0});

    // clr 3 ns into T4 of an add: everything drops without a clock edge.
    IR = 32'h1A8A0000;
    step(); check("abort_T1", {8'd0, outs}, {8'd0, E_T1});
    step(); check("abort_T2", {8'd0, outs}, {8'd0, E_T2});
    step(); check("abort_T3", {8'd0, outs}, {8'd0, E_BIN3});
    step(); check("abort_T4", {8'd0, outs}, {8'd0, E_BIN4 | M_ADD});
    #2;
    clr = 1'b1;
    #0.1;
    check("abort_outs_zero", {8'd0, outs}, 32'd0);
    check("abort_onehot0", {31'd0, $onehot0({ADD, SUB, AND, OR, NEG, NOT})}, 32'd1);
    step(); check("abort_hold", {8'd0, outs}, 32'd0);
    clr = 1'b0;
    step(); check("abort_restart_T0", {8'd0, outs}, {8'd0, E_T0});
    step(); check("abort_restart_T1", {8'd0, outs}, {8'd0, E_T1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
